// File: rtl/usb_ep_tx_fill.sv
// -----------------------------------------------------------------------------
// usb_ep_tx_fill
// Loads a byte stream into the USB endpoint TX buffer. A fill command gives
// the first word address and a byte limit. Stream bytes are packed
// little-endian into EP_BUF_WIDTH-bit words and written through the ep_tx_*
// port. When the fill ends, a one-cycle done pulse reports the byte count and
// whether s_last or the byte limit ended the packet.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         fill command handshake (ready only in IDLE)
//   cmd_base, cmd_maxlen        first word address, byte limit (0..1023)
//   s_data/s_valid/s_last       byte stream input
//   s_ready                     byte is accepted when s_valid & s_ready
//   ep_tx_addr_0/data_0/wmsk_0  TX buffer word write (wmsk 1 = lane not written)
//   ep_tx_we_0                  one-cycle write strobe per word
//   done_stb/done_len/done_last fill completion report
// All outputs come from flops. Ready signals depend only on the next state.
// -----------------------------------------------------------------------------
module usb_ep_tx_fill #(
    parameter  int EP_BUF_SIZE  = 11,
    parameter  int EP_BUF_WIDTH = 16,
    localparam int EPDW         = EP_BUF_WIDTH,
    localparam int EPMW         = EP_BUF_WIDTH / 8,
    localparam int EPAW         = EP_BUF_SIZE - $clog2(EPMW)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [EPAW-1:0] cmd_base,
    input  logic [9:0]      cmd_maxlen,
    input  logic [7:0]      s_data,
    input  logic            s_valid,
    input  logic            s_last,
    output logic            s_ready,
    output logic [EPAW-1:0] ep_tx_addr_0,
    output logic [EPDW-1:0] ep_tx_data_0,
    output logic [EPMW-1:0] ep_tx_wmsk_0,
    output logic            ep_tx_we_0,
    output logic            done_stb,
    output logic [9:0]      done_len,
    output logic            done_last
);

    localparam int LW = (EPMW > 1) ? $clog2(EPMW) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [EPAW-1:0] addr_q, addr_d;
    logic [9:0]      len_q, len_d;
    logic [9:0]      maxlen_q, maxlen_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [EPDW-1:0] pack_data_q, pack_data_d;
    logic [EPMW-1:0] pack_msk_q, pack_msk_d;
    logic            last_q, last_d;
    logic [EPAW-1:0] ep_addr_q, ep_addr_d;
    logic [EPDW-1:0] ep_data_q, ep_data_d;
    logic [EPMW-1:0] ep_wmsk_q, ep_wmsk_d;
    logic            ep_we_q, ep_we_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            s_ready_q, s_ready_d;
    logic            done_stb_q, done_stb_d;
    logic [9:0]      done_len_q, done_len_d;
    logic            done_last_q, done_last_d;

    logic            byte_acc_s;
    logic            word_full_s;
    logic            end_pkt_s;
    logic [9:0]      len_inc_s;
    logic [EPDW-1:0] word_data_s;
    logic [EPMW-1:0] word_msk_s;

    // Pending word with the incoming byte merged into the current lane.
    always_comb begin
        word_data_s                  = pack_data_q;
        word_data_s[8*lane_q +: 8]   = s_data;
        word_msk_s                   = pack_msk_q;
        word_msk_s[lane_q]           = 1'b0;
        byte_acc_s  = (state_q == FILL) && s_valid && s_ready_q;
        len_inc_s   = len_q + 10'd1;
        word_full_s = (lane_q == LW'(EPMW - 1));
        end_pkt_s   = s_last || (len_inc_s == maxlen_q);
    end

    // Next-state and datapath update for the fill sequence.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        maxlen_d    = maxlen_q;
        lane_d      = lane_q;
        pack_data_d = pack_data_q;
        pack_msk_d  = pack_msk_q;
        last_d      = last_q;
        ep_we_d     = 1'b0;
        ep_addr_d   = ep_addr_q;
        ep_data_d   = ep_data_q;
        ep_wmsk_d   = ep_wmsk_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d      = cmd_base;
                    maxlen_d    = cmd_maxlen;
                    len_d       = 10'd0;
                    lane_d      = '0;
                    pack_data_d = '0;
                    pack_msk_d  = {EPMW{1'b1}};
                    last_d      = 1'b0;
                    // A zero-length fill still passes through FLUSH so the
                    // done pulse keeps the same cycle distance from accept.
                    if (cmd_maxlen == 10'd0) begin
                        state_d = FLUSH;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                if (byte_acc_s) begin
                    len_d = len_inc_s;
                    if (word_full_s || end_pkt_s) begin
                        // Word complete or packet ends: emit it next cycle.
                        ep_we_d     = 1'b1;
                        ep_addr_d   = addr_q;
                        ep_data_d   = word_data_s;
                        ep_wmsk_d   = word_msk_s;
                        addr_d      = addr_q + EPAW'(1);
                        pack_data_d = '0;
                        pack_msk_d  = {EPMW{1'b1}};
                        lane_d      = '0;
                    end else begin
                        pack_data_d = word_data_s;
                        pack_msk_d  = word_msk_s;
                        lane_d      = lane_q + LW'(1);
                    end
                    if (end_pkt_s) begin
                        last_d  = s_last;
                        state_d = FLUSH;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    state_d = FILL;
                end
            end
            FLUSH: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered handshake and completion outputs, decoded from the next state.
    always_comb begin
        cmd_ready_d = (state_d == IDLE);
        s_ready_d   = (state_d == FILL) && (len_d < maxlen_d);
        done_stb_d  = (state_d == DONE);
        if (state_d == DONE) begin
            done_len_d  = len_d;
            done_last_d = last_d;
        end else begin
            done_len_d  = done_len_q;
            done_last_d = done_last_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= 10'd0;
            maxlen_q    <= 10'd0;
            lane_q      <= '0;
            pack_data_q <= '0;
            pack_msk_q  <= {EPMW{1'b1}};
            last_q      <= 1'b0;
            ep_addr_q   <= '0;
            ep_data_q   <= '0;
            ep_wmsk_q   <= '0;
            ep_we_q     <= 1'b0;
            cmd_ready_q <= 1'b1;
            s_ready_q   <= 1'b0;
            done_stb_q  <= 1'b0;
            done_len_q  <= 10'd0;
            done_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            maxlen_q    <= maxlen_d;
            lane_q      <= lane_d;
            pack_data_q <= pack_data_d;
            pack_msk_q  <= pack_msk_d;
            last_q      <= last_d;
            ep_addr_q   <= ep_addr_d;
            ep_data_q   <= ep_data_d;
            ep_wmsk_q   <= ep_wmsk_d;
            ep_we_q     <= ep_we_d;
            cmd_ready_q <= cmd_ready_d;
            s_ready_q   <= s_ready_d;
            done_stb_q  <= done_stb_d;
            done_len_q  <= done_len_d;
            done_last_q <= done_last_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign s_ready      = s_ready_q;
    assign ep_tx_addr_0 = ep_addr_q;
    assign ep_tx_data_0 = ep_data_q;
    assign ep_tx_wmsk_0 = ep_wmsk_q;
    assign ep_tx_we_0   = ep_we_q;
    assign done_stb     = done_stb_q;
    assign done_len     = done_len_q;
    assign done_last    = done_last_q;

endmodule

// File: tb/tb_usb_ep_tx_fill.sv
// -----------------------------------------------------------------------------
// tb_usb_ep_tx_fill
// Scoreboard bench for usb_ep_tx_fill with EP_BUF_WIDTH=16 (EPAW=10).
// Expected words and done reports are queued when a fill is set up and popped
// by a negedge monitor whenever the DUT writes or signals done.
// -----------------------------------------------------------------------------
module tb_usb_ep_tx_fill;

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] data;
        logic [1:0]  msk;
    } wr_t;

    typedef struct {
        logic [9:0] len;
        logic       last;
    } done_t;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_base;
    logic [9:0]  cmd_maxlen;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [9:0]  ep_tx_addr_0;
    logic [15:0] ep_tx_data_0;
    logic [1:0]  ep_tx_wmsk_0;
    logic        ep_tx_we_0;
    logic        done_stb;
    logic [9:0]  done_len;
    logic        done_last;

    usb_ep_tx_fill #(.EP_BUF_SIZE(11), .EP_BUF_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base(cmd_base), .cmd_maxlen(cmd_maxlen),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .ep_tx_addr_0(ep_tx_addr_0), .ep_tx_data_0(ep_tx_data_0),
        .ep_tx_wmsk_0(ep_tx_wmsk_0), .ep_tx_we_0(ep_tx_we_0),
        .done_stb(done_stb), .done_len(done_len), .done_last(done_last)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         last_we_cyc = 0;
    int         acc_cyc  = 0;
    int         ready_hi = 0;
    wr_t        exp_wr[$];
    done_t      exp_done[$];
    logic [7:0] byte_q[$];
    bit         has_last;
    bit         gap_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cycle counter, stepped on every active edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // monitor: compare every write and done report against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_ready) ready_hi++;
            if (ep_tx_we_0) begin
                last_we_cyc = cyc;
                if (exp_wr.size() == 0) begin
                    check_eq("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    wr_t         e;
                    logic [15:0] lanes;
                    e     = exp_wr.pop_front();
                    lanes = {{8{~e.msk[1]}}, {8{~e.msk[0]}}};
                    check_eq("wr_addr", 32'(ep_tx_addr_0), 32'(e.addr));
                    check_eq("wr_data", 32'(ep_tx_data_0 & lanes), 32'(e.data & lanes));
                    check_eq("wr_msk", 32'(ep_tx_wmsk_0), 32'(e.msk));
                end
            end
            if (done_stb) begin
                done_cyc = cyc;
                if (exp_done.size() == 0) begin
                    check_eq("done_unexpected", 32'd1, 32'd0);
                end else begin
                    done_t d;
                    d = exp_done.pop_front();
                    check_eq("done_len", 32'(done_len), 32'(d.len));
                    check_eq("done_last", 32'(done_last), 32'(d.last));
                end
                done_cnt++;
            end
        end
    end

    // reference model: pack byte_q little-endian into 16-bit words
    task automatic expect_fill(input logic [9:0] base, input int maxlen, output int take);
        int         n;
        int         lane;
        logic [9:0] a;
        wr_t        w;
        done_t      d;
        n      = byte_q.size();
        take   = (n < maxlen) ? n : maxlen;
        a      = base;
        w.data = 16'h0000;
        w.msk  = 2'b11;
        for (int i = 0; i < take; i++) begin
            lane = i % 2;
            w.data[8*lane +: 8] = byte_q[i];
            w.msk[lane] = 1'b0;
            if (lane == 1 || i == take - 1) begin
                w.addr = a;
                exp_wr.push_back(w);
                a      = a + 10'd1;
                w.data = 16'h0000;
                w.msk  = 2'b11;
            end
        end
        d.len  = 10'(take);
        d.last = has_last && (n > 0) && (n <= maxlen);
        exp_done.push_back(d);
    endtask

    task automatic send_cmd(input logic [9:0] base, input logic [9:0] maxlen);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid  = 1'b1;
        cmd_base   = base;
        cmd_maxlen = maxlen;
        acc_cyc    = cyc;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    // drive byte_q until done is seen or stop_after bytes are accepted
    task automatic stream(input int stop_after, output int consumed);
        int start_done;
        int guard;
        bit acc;
        start_done = done_cnt;
        consumed   = 0;
        guard      = 0;
        acc        = 1'b0;
        while (done_cnt == start_done && consumed < stop_after && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (acc) consumed++;
            if (consumed < byte_q.size() && consumed < stop_after) begin
                s_valid = gap_en ? 1'($urandom_range(0, 1)) : 1'b1;
                s_data  = byte_q[consumed];
                s_last  = has_last && (consumed == byte_q.size() - 1);
            end else begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
            acc = s_valid && s_ready;
        end
        check_eq("stream_timeout", 32'(guard >= 2000), 32'd0);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_fill(input string tag, input logic [9:0] base, input int maxlen);
        int take;
        int consumed;
        ready_hi = 0;
        expect_fill(base, maxlen, take);
        send_cmd(base, 10'(maxlen));
        stream(1 << 30, consumed);
        check_eq({tag, "_consumed"}, 32'(consumed), 32'(take));
        if (take > 0) begin
            check_eq({tag, "_done_after_we"}, 32'(done_cyc - last_we_cyc), 32'd1);
        end else begin
            check_eq({tag, "_done_after_cmd"}, 32'(done_cyc - acc_cyc), 32'd2);
            check_eq({tag, "_ready_hi"}, 32'(ready_hi), 32'd0);
        end
        check_eq({tag, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
        check_eq({tag, "_done_left"}, 32'(exp_done.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check_eq({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        check_eq({tag, "_we"}, 32'(ep_tx_we_0), 32'd0);
        check_eq({tag, "_addr"}, 32'(ep_tx_addr_0), 32'd0);
        check_eq({tag, "_data"}, 32'(ep_tx_data_0), 32'd0);
        check_eq({tag, "_wmsk"}, 32'(ep_tx_wmsk_0), 32'd0);
        check_eq({tag, "_done_stb"}, 32'(done_stb), 32'd0);
        check_eq({tag, "_done_len"}, 32'(done_len), 32'd0);
        check_eq({tag, "_done_last"}, 32'(done_last), 32'd0);
    endtask

    initial begin
        int consumed;
        int saved_done;
        wr_t w;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_base = 10'd0; cmd_maxlen = 10'd0;
        s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0; gap_en = 1'b0; has_last = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;

        // T1: five bytes ending with s_last, odd count leaves lane 1 unwritten
        byte_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15}; has_last = 1'b1;
        run_fill("t1", 10'h010, 64);

        // T2: byte limit reached before the stream ends; A4 stays unconsumed
        byte_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5}; has_last = 1'b0;
        run_fill("t2", 10'h000, 4);

        // T3: zero-length fill
        byte_q = '{8'h55}; has_last = 1'b1;
        run_fill("t3", 10'h100, 0);

        // T4: address wraps from the top word to zero
        byte_q = '{8'h01, 8'h02, 8'h03, 8'h04}; has_last = 1'b1;
        run_fill("t4", 10'h3FF, 4);

        // s_last on the byte that also reaches the limit reports done_last=1
        byte_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25}; has_last = 1'b1;
        run_fill("lastmax", 10'h040, 5);

        // T5: 33 bytes with random stream gaps
        byte_q.delete();
        for (int i = 0; i < 33; i++) byte_q.push_back(8'($urandom_range(0, 255)));
        has_last = 1'b1; gap_en = 1'b1;
        run_fill("t5", 10'h200, 64);
        gap_en = 1'b0;

        // T6: reset during a fill after three bytes; only the first word lands
        byte_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5}; has_last = 1'b0;
        w.addr = 10'h020; w.data = 16'hB1B0; w.msk = 2'b00;
        exp_wr.push_back(w);
        saved_done = done_cnt;
        send_cmd(10'h020, 10'd10);
        stream(3, consumed);
        check_eq("t6_consumed", 32'(consumed), 32'd3);
        rst_n = 1'b0;
        #1;
        check_reset_values("t6");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("t6_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("t6_no_done", 32'(done_cnt), 32'(saved_done));
        check_eq("t6_wr_left", 32'(exp_wr.size()), 32'd0);

        // after the abort, a new fill starts clean on lane 0
        byte_q = '{8'hC0, 8'hC1}; has_last = 1'b0;
        run_fill("post_rst", 10'h030, 2);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
